// File: rtl/logica_condicional_pkg.sv
// pkg_condicional: shared types and constants for the condition-execution unit.
`default_nettype none

package pkg_condicional;

   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_t;

   localparam int IDX_N = 3;
   localparam int IDX_Z = 2;
   localparam int IDX_C = 1;
   localparam int IDX_V = 0;

   typedef enum logic {
      VACIO = 1'b0,
      LLENO = 1'b1
   } estado_t;

endpackage

`default_nettype wire

// File: rtl/logica_condicional_evaluador_condicion.sv
// evaluador_condicion: combinational ARM condition-field check against NZCV.
`default_nettype none

module evaluador_condicion
   import pkg_condicional::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags_nzcv,
   output logic       condEx
);

   logic n, z, c, v;

   assign n = flags_nzcv[IDX_N];
   assign z = flags_nzcv[IDX_Z];
   assign c = flags_nzcv[IDX_C];
   assign v = flags_nzcv[IDX_V];

   always_comb begin
      condEx = 1'b0;
      case (cond_t'(cond))
         EQ:      condEx = z;
         NE:      condEx = !z;
         CS:      condEx = c;
         CC:      condEx = !c;
         MI:      condEx = n;
         PL:      condEx = !n;
         VS:      condEx = v;
         VC:      condEx = !v;
         HI:      condEx = c && !z;
         LS:      condEx = !c || z;
         GE:      condEx = (n == v);
         LT:      condEx = (n != v);
         GT:      condEx = !z && (n == v);
         LE:      condEx = z || (n != v);
         AL:      condEx = 1'b1;
         // Reserved encoding always squashes.
         default: condEx = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/logica_condicional.sv
// logica_condicional: NZCV register, condition gating of write intents,
// one-entry valid/ready output stage and saturating statistics counters.
`default_nettype none

module logica_condicional
   import pkg_condicional::*;
#(
   parameter int CONT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              entrada_valida,
   output logic              entrada_lista,
   input  logic [3:0]        cond,
   input  logic              flagNegativo,
   input  logic              flagCero,
   input  logic              flagOverflow,
   input  logic              flagCarry,
   input  logic [1:0]        FlagW,
   input  logic              PCS,
   input  logic              RegW,
   input  logic              MemW,
   output logic              salida_valida,
   input  logic              salida_lista,
   output logic              PCSrc,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic [3:0]        flags_nzcv,
   output logic [CONT_W-1:0] cuenta_ejecutadas,
   output logic [CONT_W-1:0] cuenta_anuladas
);

   localparam logic [CONT_W-1:0] CONT_MAX = '1;
   localparam logic [CONT_W-1:0] CONT_UNO = CONT_W'(1);

   estado_t estado;
   logic    cond_ex;
   logic    aceptar;

   // Condition is evaluated on the flags held before the accepting edge.
   evaluador_condicion u_evaluador (
      .cond       (cond),
      .flags_nzcv (flags_nzcv),
      .condEx     (cond_ex)
   );

   assign salida_valida = (estado == LLENO);
   assign entrada_lista = !salida_valida || salida_lista;
   assign aceptar       = entrada_valida && entrada_lista;

   always_ff @(posedge clk) begin
      if (reset) begin
         estado            <= VACIO;
         PCSrc             <= 1'b0;
         RegWrite          <= 1'b0;
         MemWrite          <= 1'b0;
         flags_nzcv        <= 4'b0000;
         cuenta_ejecutadas <= '0;
         cuenta_anuladas   <= '0;
      end else begin
         if (aceptar) begin
            estado   <= LLENO;
            PCSrc    <= PCS  && cond_ex;
            RegWrite <= RegW && cond_ex;
            MemWrite <= MemW && cond_ex;
            if (cond_ex) begin
               if (FlagW[1]) begin
                  flags_nzcv[IDX_N] <= flagNegativo;
                  flags_nzcv[IDX_Z] <= flagCero;
               end
               if (FlagW[0]) begin
                  flags_nzcv[IDX_C] <= flagCarry;
                  flags_nzcv[IDX_V] <= flagOverflow;
               end
               if (cuenta_ejecutadas != CONT_MAX)
                  cuenta_ejecutadas <= cuenta_ejecutadas + CONT_UNO;
            end else if (cuenta_anuladas != CONT_MAX) begin
               cuenta_anuladas <= cuenta_anuladas + CONT_UNO;
            end
         end else if (salida_lista) begin
            estado <= VACIO;
         end
      end
   end

endmodule

`default_nettype wire
